dnn_accel_bank_pipe: RTL
========================

DNN_ACCEL_BANK_PIPE -- requirements
Module: dnn_accel_bank_pipe

Interface
REQ-001 Parameter DATA_W, default 32, word width; SHALL be a multiple of 8, range 8..128.
REQ-002 Parameter ADDR_W, default 10, word address width; depth = 2^ADDR_W.
REQ-003 Parameter READ_LATENCY, default 2, cycles from read acceptance to readdatavalid; legal range 1..4.
REQ-004 Parameter CLEAR_ON_RESET, default 0; when 1, a zero-fill sweep starts automatically after reset deasserts.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 address  in  ADDR_W  word address.
REQ-008 chipselect  in  1  slave select.
REQ-009 read  in  1  read request.
REQ-010 write  in  1  write request.
REQ-011 byteenable  in  DATA_W/8  write byte-lane enables.
REQ-012 writedata  in  DATA_W  write data.
REQ-013 clken  in  1  global clock enable; low freezes all state.
REQ-014 clear_req  in  1  request to zero-fill entire memory.
REQ-015 readdata  out  DATA_W  read data.
REQ-016 readdatavalid  out  1  one-cycle pulse per returned read.
REQ-017 waitrequest  out  1  command not accepted this cycle.
REQ-018 clear_busy  out  1  drain or sweep in progress.

Function
REQ-019 Command SHALL be accepted in a cycle where chipselect & (read|write) & clken & ~waitrequest.
REQ-020 waitrequest SHALL equal ~clken | (FSM != IDLE).
REQ-021 read & write both high SHALL be treated as a write only; no readdatavalid is produced.
REQ-022 Accepted write SHALL update only lanes with byteenable=1; an all-zero byteenable write SHALL be accepted with no effect.
REQ-023 Accepted read SHALL yield readdatavalid exactly READ_LATENCY enabled cycles later, in acceptance order; back-to-back reads every cycle SHALL be sustained.
REQ-024 Read data SHALL reflect memory contents at acceptance: a write accepted at cycle N is visible to a read accepted at N+1; a write accepted after a read leaves that read's data unchanged.
REQ-025 readdata SHALL hold its last returned value while readdatavalid is low.
REQ-026 clken low SHALL freeze the read pipeline, FSM, sweep address and outputs; no readdatavalid pulse SHALL be issued while clken is low.
REQ-027 An outstanding-read counter (0..READ_LATENCY) SHALL track reads in flight.
REQ-028 FSM states: IDLE, DRAIN, CLEAR.
REQ-029 IDLE -> DRAIN when clear_req=1 and outstanding>0; IDLE -> CLEAR when clear_req=1 and outstanding=0.
REQ-030 A command accepted in the same cycle as clear_req SHALL complete normally; it counts toward the outstanding reads for the DRAIN decision.
REQ-031 DRAIN -> CLEAR when outstanding reaches 0; all pending readdatavalid pulses SHALL still be delivered.
REQ-032 CLEAR SHALL write zero to addresses 0..2^ADDR_W-1 ascending, one per enabled cycle, then return to IDLE; the sweep takes 2^ADDR_W enabled cycles.
REQ-033 clear_busy SHALL be high in DRAIN and CLEAR only; clear_req SHALL be ignored outside IDLE.

Reset
REQ-034 Asserting reset SHALL immediately force readdata=0, readdatavalid=0, outstanding=0, sweep address=0, and discard in-flight reads.
REQ-035 While reset is asserted, the FSM SHALL be in IDLE if CLEAR_ON_RESET=0, or in CLEAR if CLEAR_ON_RESET=1.
REQ-036 Reset asserted mid-sweep SHALL abort the sweep; contents are otherwise preserved, and there is no re-sweep unless CLEAR_ON_RESET=1.
REQ-037 Memory contents SHALL NOT be cleared by reset itself.

Verification (DATA_W=32, ADDR_W=10, READ_LATENCY=2)
REQ-038 Write 0xDEADBEEF at 0x005 with byteenable=0xF, then with byteenable=0x3 write 0x00001234 -> read 0x005 returns 0xDEAD1234 with readdatavalid 2 cycles after acceptance.
REQ-039 Write 0x11111111 at 0x010 in cycle N and read 0x010 in cycle N+1 -> 0x11111111; read 0x020 in cycle M and write 0x020 in cycle M+1 -> the read returns the old value.
REQ-040 Issue 8 back-to-back reads of 0x000..0x007 -> 8 consecutive readdatavalid pulses, in order, with zero waitrequest cycles.
REQ-041 Issue 2 reads, then clear_req in the next cycle -> FSM enters DRAIN, both reads are delivered, then the sweep runs; clear_busy stays high for 2+1024 cycles; waitrequest is high throughout; all words read 0 afterwards.
REQ-042 Drop clken for 3 cycles while 2 reads are in flight -> no pulses during the stall; pulses resume afterwards with unchanged data and ordering.
REQ-043 Assert reset at sweep address 0x200 -> outputs go 0 asynchronously; FSM is IDLE after reset; address 0x300 retains its pre-clear data.

Source files
------------

// File: rtl/dnn_accel_bank_pipe.sv
// ---------------------------------------------------------------------------
// dnn_accel_bank_pipe
//
// Single-port memory bank with a fixed-latency pipelined read path. It also
// has a zero-fill engine that first waits for in-flight reads to drain and
// then sweeps the whole array.
//
// Ports
//   clk           : single clock; all logic uses the rising edge
//   reset         : asynchronous, active-high
//   address       : word address
//   chipselect    : slave select
//   read / write  : command strobes (both high is treated as a write)
//   byteenable    : per-lane write enables
//   writedata     : write data
//   clken         : global clock enable; low freezes every piece of state
//   clear_req     : request to zero-fill the whole memory
//   readdata      : returned read data; holds its value between returns
//   readdatavalid : one-cycle pulse for each returned read
//   waitrequest   : command not accepted this cycle
//   clear_busy    : drain or sweep in progress
// ---------------------------------------------------------------------------
module dnn_accel_bank_pipe #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 10,
    parameter int READ_LATENCY   = 2,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  clken,
    input  logic                  clear_req,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  clear_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [ADDR_W-1:0] SWEEP_LAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     sweepAddr_q, sweepAddr_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [READ_LATENCY-1:0] validPipe_q;
    logic [DATA_W-1:0]     dataPipe_q [READ_LATENCY];
    logic [DATA_W-1:0]     mem [DEPTH];

    logic cmdAccept;
    logic readAccept;
    logic writeAccept;
    logic deliver;

    // Handshake. Read and write together is a write, so such a command never
    // enters the read pipeline. A pulse only counts as delivered in a cycle
    // where clken is high.
    assign waitrequest   = ~clken | (state_q != IDLE);
    assign cmdAccept     = chipselect & (read | write) & ~waitrequest;
    assign readAccept    = cmdAccept & read & ~write;
    assign writeAccept   = cmdAccept & write;
    assign deliver       = validPipe_q[READ_LATENCY-1] & clken;

    assign readdata      = dataPipe_q[READ_LATENCY-1];
    assign readdatavalid = deliver;
    assign clear_busy    = (state_q != IDLE);

    // Reads in flight. An accept and a delivery in the same cycle cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        if (readAccept && !deliver) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!readAccept && deliver) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    // Clear sequencing. A read accepted in the same cycle as clear_req forces
    // the drain path, so its pulse still arrives before the sweep starts. The
    // sweep address wraps back to zero on its last step.
    always_comb begin
        state_d     = state_q;
        sweepAddr_d = sweepAddr_q;
        if (clken) begin
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_d = (outstanding_q != '0 || readAccept) ? DRAIN : CLEAR;
                    end
                end
                DRAIN: begin
                    if (outstanding_q == '0) begin
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    sweepAddr_d = sweepAddr_q + 1'b1;
                    if (sweepAddr_q == SWEEP_LAST) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control registers. The next-state logic already holds its value when
    // clken is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RESET_STATE;
            sweepAddr_q   <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            sweepAddr_q   <= sweepAddr_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Read pipeline. Stage 0 captures the word at acceptance, so a later
    // write cannot change data that is already in flight. The last stage only
    // loads on a valid entry, so readdata holds between returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validPipe_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dataPipe_q[i] <= '0;
            end
        end else if (clken) begin
            validPipe_q[0] <= readAccept;
            if (READ_LATENCY > 1 || readAccept) begin
                dataPipe_q[0] <= mem[address];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                validPipe_q[i] <= validPipe_q[i-1];
                if (i < READ_LATENCY - 1 || validPipe_q[i-1]) begin
                    dataPipe_q[i] <= dataPipe_q[i-1];
                end
            end
        end
    end

    // Storage array. This block has no reset, so contents survive reset.
    // Sweep writes and host writes never coincide, because waitrequest is high
    // whenever the sweep runs.
    always_ff @(posedge clk) begin
        if (clken) begin
            if (state_q == CLEAR) begin
                mem[sweepAddr_q] <= '0;
            end else if (writeAccept) begin
                for (int b = 0; b < DATA_W / 8; b++) begin
                    if (byteenable[b]) begin
                        mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule
